// File: rtl/simon_sequencer.sv
// Simon game engine: LFSR-generated colour sequence, timed LED replay and
// step-by-step checking of player presses. One colour is added per round;
// the game ends in WIN after MAX_LEN rounds or in LOSE on a wrong colour or
// an input timeout. All timing is measured in 'tick' pulses.
module simon_sequencer #(
   parameter int COLOR_W       = 2,
   parameter int MAX_LEN       = 16,
   parameter int LEN_W         = 5,
   parameter int SHOW_TICKS    = 2,
   parameter int GAP_TICKS     = 1,
   parameter int TIMEOUT_TICKS = 0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               tick,
   input  logic               start,
   input  logic [15:0]        seed,
   input  logic               btn_valid,
   input  logic [COLOR_W-1:0] btn_color,
   output logic               led_on,
   output logic [COLOR_W-1:0] led_color,
   output logic [LEN_W-1:0]   round,
   output logic [LEN_W-1:0]   step,
   output logic               showing,
   output logic               awaiting,
   output logic               win,
   output logic               lose,
   output logic               lose_cause
);

   // Tick counter must hold the longest of the three programmable intervals.
   localparam int TMAX_A = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
   localparam int TMAX   = (TMAX_A > TIMEOUT_TICKS) ? TMAX_A : TIMEOUT_TICKS;
   localparam int CNT_W  = $clog2(TMAX + 1);
   localparam int IDX_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SHOW_TICKS - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_TICKS - 1);
   localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'((TIMEOUT_TICKS > 0) ? TIMEOUT_TICKS - 1 : 0);
   localparam logic [LEN_W-1:0] ROUND_MAX = LEN_W'(MAX_LEN);
   localparam logic [15:0]      ZERO_SEED = 16'hACE1;

   typedef enum logic [2:0] {
      S_IDLE, S_APPEND, S_SHOW_ON, S_SHOW_OFF, S_INPUT, S_WIN, S_LOSE
   } state_t;

   state_t               state_q, state_d;
   logic [LEN_W-1:0]     round_q, round_d;
   logic [LEN_W-1:0]     step_q, step_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [15:0]          lfsr_q, lfsr_d;
   logic                 lose_cause_q, lose_cause_d;
   logic                 led_on_q, led_on_d;
   logic [COLOR_W-1:0]   led_color_q, led_color_d;
   logic                 showing_q, showing_d;
   logic                 awaiting_q, awaiting_d;
   logic                 win_q, win_d;
   logic                 lose_q, lose_d;

   // Sequence memory is intentionally left out of reset.
   logic [COLOR_W-1:0]   mem_q [MAX_LEN];
   logic                 mem_we;
   logic [15:0]          lfsr_adv;
   logic [COLOR_W-1:0]   new_color;
   logic [COLOR_W-1:0]   exp_color;
   logic [COLOR_W-1:0]   show_color;
   logic                 last_step;

   // Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1, shifting right.
   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      logic fb;
      fb = v[0] ^ v[2] ^ v[3] ^ v[5];
      return {fb, v[15:1]};
   endfunction

   assign lfsr_adv  = lfsr_next(lfsr_q);
   assign new_color = lfsr_adv[COLOR_W-1:0];
   assign exp_color = mem_q[step_q[IDX_W-1:0]];
   assign last_step = (step_q == (round_q - LEN_W'(1)));

   // Colour to display on entering SHOW_ON; bypasses the memory when the
   // element being shown is the one written on this same edge.
   assign show_color = (mem_we && (step_d == round_q)) ? new_color
                                                       : mem_q[step_d[IDX_W-1:0]];

   // State register and datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         round_q      <= '0;
         step_q       <= '0;
         cnt_q        <= '0;
         lfsr_q       <= '0;
         lose_cause_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         round_q      <= round_d;
         step_q       <= step_d;
         cnt_q        <= cnt_d;
         lfsr_q       <= lfsr_d;
         lose_cause_q <= lose_cause_d;
      end
   end

   // Sequence memory write, one colour per APPEND.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[round_q[IDX_W-1:0]] <= new_color;
      end
   end

   // Next-state logic, including round/step/tick-counter/LFSR updates.
   always_comb begin
      state_d      = state_q;
      round_d      = round_q;
      step_d       = step_q;
      cnt_d        = cnt_q;
      lfsr_d       = lfsr_q;
      lose_cause_d = lose_cause_q;
      mem_we       = 1'b0;
      case (state_q)
         S_IDLE, S_WIN, S_LOSE: begin
            if (start) begin
               lfsr_d       = (seed == 16'h0000) ? ZERO_SEED : seed;
               round_d      = '0;
               step_d       = '0;
               cnt_d        = '0;
               lose_cause_d = 1'b0;
               state_d      = S_APPEND;
            end
         end
         S_APPEND: begin
            lfsr_d  = lfsr_adv;
            mem_we  = 1'b1;
            round_d = round_q + LEN_W'(1);
            step_d  = '0;
            cnt_d   = '0;
            state_d = S_SHOW_ON;
         end
         S_SHOW_ON: begin
            if (tick) begin
               if (cnt_q == SHOW_LAST) begin
                  cnt_d   = '0;
                  state_d = S_SHOW_OFF;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         S_SHOW_OFF: begin
            if (tick) begin
               if (cnt_q == GAP_LAST) begin
                  cnt_d = '0;
                  if (last_step) begin
                     step_d  = '0;
                     state_d = S_INPUT;
                  end else begin
                     step_d  = step_q + LEN_W'(1);
                     state_d = S_SHOW_ON;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         S_INPUT: begin
            // A press always wins over a timeout expiring in the same cycle.
            if (btn_valid) begin
               cnt_d = '0;
               if (btn_color != exp_color) begin
                  lose_cause_d = 1'b0;
                  state_d      = S_LOSE;
               end else if (!last_step) begin
                  step_d = step_q + LEN_W'(1);
               end else if (round_q == ROUND_MAX) begin
                  state_d = S_WIN;
               end else begin
                  state_d = S_APPEND;
               end
            end else if ((TIMEOUT_TICKS > 0) && tick) begin
               if (cnt_q == TO_LAST) begin
                  cnt_d        = '0;
                  lose_cause_d = 1'b1;
                  state_d      = S_LOSE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output decode from the next state so that outputs change with the transition.
   always_comb begin
      led_on_d    = (state_d == S_SHOW_ON);
      led_color_d = (state_d == S_SHOW_ON) ? show_color : '0;
      showing_d   = (state_d == S_SHOW_ON) || (state_d == S_SHOW_OFF);
      awaiting_d  = (state_d == S_INPUT);
      win_d       = (state_d == S_WIN);
      lose_d      = (state_d == S_LOSE);
   end

   // Registered status outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         led_on_q    <= 1'b0;
         led_color_q <= '0;
         showing_q   <= 1'b0;
         awaiting_q  <= 1'b0;
         win_q       <= 1'b0;
         lose_q      <= 1'b0;
      end else begin
         led_on_q    <= led_on_d;
         led_color_q <= led_color_d;
         showing_q   <= showing_d;
         awaiting_q  <= awaiting_d;
         win_q       <= win_d;
         lose_q      <= lose_d;
      end
   end

   assign led_on     = led_on_q;
   assign led_color  = led_color_q;
   assign round      = round_q;
   assign step       = step_q;
   assign showing    = showing_q;
   assign awaiting   = awaiting_q;
   assign win        = win_q;
   assign lose       = lose_q;
   assign lose_cause = lose_cause_q;

endmodule

// File: tb/tb_simon_sequencer.sv
// Bench for simon_sequencer: plays whole games against a reference sequence
// derived from the seed and a tick-counting model of replay timing.
module tb_simon_sequencer;
   localparam int COLOR_W = 2;
   localparam int MAX_LEN = 4;
   localparam int LEN_W   = 5;
   localparam int SHOW    = 2;
   localparam int GAP     = 1;
   localparam int TO      = 5;

   logic               clk = 1'b0;
   logic               reset;
   logic               tick;
   logic               start;
   logic [15:0]        seed;
   logic               btn_valid;
   logic [COLOR_W-1:0] btn_color;
   logic               led_on;
   logic [COLOR_W-1:0] led_color;
   logic [LEN_W-1:0]   round;
   logic [LEN_W-1:0]   step;
   logic               showing;
   logic               awaiting;
   logic               win;
   logic               lose;
   logic               lose_cause;

   simon_sequencer #(
      .COLOR_W(COLOR_W), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W),
      .SHOW_TICKS(SHOW), .GAP_TICKS(GAP), .TIMEOUT_TICKS(TO)
   ) dut (
      .clk(clk), .reset(reset), .tick(tick), .start(start), .seed(seed),
      .btn_valid(btn_valid), .btn_color(btn_color),
      .led_on(led_on), .led_color(led_color), .round(round), .step(step),
      .showing(showing), .awaiting(awaiting), .win(win), .lose(lose),
      .lose_cause(lose_cause)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc_n  = 0;
   int tper   = 1;
   logic [COLOR_W-1:0] exp_seq  [MAX_LEN];
   logic [COLOR_W-1:0] obs_seq  [MAX_LEN];
   logic [COLOR_W-1:0] save_seq [MAX_LEN];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock: the posedge consumes the current inputs; pulses then drop.
   task automatic advance();
      @(negedge clk);
      cyc_n++;
      start     = 1'b0;
      btn_valid = 1'b0;
      tick      = ((cyc_n % tper) == 0);
   endtask

   // Expected colour sequence straight from the LFSR definition.
   task automatic model_seq(input logic [15:0] sd);
      int s;
      int b;
      s = (sd == 16'h0000) ? 32'hACE1 : int'(sd);
      for (int i = 0; i < MAX_LEN; i++) begin
         b = ((s >> 0) ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 1;
         s = ((s >> 1) | (b << 15)) & 32'hFFFF;
         exp_seq[i] = COLOR_W'(s % (1 << COLOR_W));
      end
   endtask

   task automatic replay(input int r, input bit inject);
      int cnt;
      int len;
      for (int i = 0; i < r; i++) begin
         cnt = 0;
         len = 0;
         while (cnt < SHOW) begin
            chk("led_on", led_on, 1);
            chk("led_color", led_color, exp_seq[i]);
            chk("show_step", step, i);
            chk("showing_on", showing, 1);
            chk("show_round", round, r);
            obs_seq[i] = led_color;
            if (inject && i == 0 && len == 0) begin
               btn_valid = 1'b1;
               btn_color = COLOR_W'($urandom_range(3));
            end
            if (tick) cnt++;
            len++;
            advance();
            if (len > 100) begin
               chk("show_bound", cnt, SHOW);
               break;
            end
         end
         if (i > 0) chk("on_len", len, SHOW * tper);
         cnt = 0;
         len = 0;
         while (cnt < GAP) begin
            chk("led_off", led_on, 0);
            chk("showing_gap", showing, 1);
            chk("gap_step", step, i);
            if (tick) cnt++;
            len++;
            advance();
            if (len > 100) begin
               chk("gap_bound", cnt, GAP);
               break;
            end
         end
         chk("off_len", len, GAP * tper);
      end
      chk("awaiting", awaiting, 1);
      chk("in_step", step, 0);
      chk("in_round", round, r);
      chk("in_showing", showing, 0);
   endtask

   task automatic press_all(input int r);
      for (int i = 0; i < r; i++) begin
         btn_valid = 1'b1;
         btn_color = exp_seq[i];
         advance();
         chk("press_lose", lose, 0);
         if (i < r - 1) begin
            chk("press_step", step, i + 1);
            chk("press_await", awaiting, 1);
         end else if (r < MAX_LEN) begin
            chk("append_await", awaiting, 0);
            chk("append_show", showing, 0);
            chk("append_round", round, r);
         end else begin
            chk("win", win, 1);
            chk("win_round", round, MAX_LEN);
            chk("win_await", awaiting, 0);
         end
      end
   endtask

   task automatic begin_game(input logic [15:0] sd);
      model_seq(sd);
      seed  = sd;
      start = 1'b1;
      advance();
      chk("start_round", round, 0);
      chk("start_win", win, 0);
      chk("start_lose", lose, 0);
      chk("start_show", showing, 0);
   endtask

   task automatic play_game(input logic [15:0] sd, input bit inject);
      begin_game(sd);
      for (int r = 1; r <= MAX_LEN; r++) begin
         advance();
         replay(r, inject && r == 2);
         if (inject && r == 3) begin
            start = 1'b1;
            seed  = 16'($urandom);
            advance();
            chk("ign_start_await", awaiting, 1);
            chk("ign_start_round", round, r);
            chk("ign_start_step", step, 0);
         end
         press_all(r);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b1;
      tick      = 1'b1;
      start     = 1'b0;
      seed      = 16'h0000;
      btn_valid = 1'b0;
      btn_color = '0;
      advance();
      advance();
      chk("rst_led_on", led_on, 0);
      chk("rst_led_color", led_color, 0);
      chk("rst_round", round, 0);
      chk("rst_step", step, 0);
      chk("rst_showing", showing, 0);
      chk("rst_awaiting", awaiting, 0);
      chk("rst_win", win, 0);
      chk("rst_lose", lose, 0);
      chk("rst_cause", lose_cause, 0);
      reset = 1'b0;

      // Reset in the middle of SHOW_ON, then the same seed replays identically.
      begin_game(16'h0001);
      advance();
      chk("pre_rst_led", led_on, 1);
      chk("pre_rst_color", led_color, exp_seq[0]);
      advance();
      #2 reset = 1'b1;
      #1;
      chk("async_led_on", led_on, 0);
      chk("async_led_color", led_color, 0);
      chk("async_round", round, 0);
      chk("async_showing", showing, 0);
      advance();
      reset = 1'b0;

      // Full winning game, ignored btn_valid in SHOW_ON and start in INPUT.
      play_game(16'h0001, 1'b1);
      advance();
      chk("win_hold", win, 1);

      // Wrong colour at step 0 of round 2.
      begin_game(16'($urandom));
      advance();
      replay(1, 1'b0);
      press_all(1);
      advance();
      replay(2, 1'b0);
      btn_valid = 1'b1;
      btn_color = exp_seq[0] ^ COLOR_W'($urandom_range(1, 3));
      advance();
      chk("wrong_lose", lose, 1);
      chk("wrong_cause", lose_cause, 0);
      chk("wrong_round", round, 2);
      chk("wrong_await", awaiting, 0);
      advance();
      chk("lose_hold", lose, 1);

      // Timeout exactly TO ticks after INPUT entry.
      begin_game(16'($urandom));
      advance();
      replay(1, 1'b0);
      for (int k = 0; k < TO - 1; k++) begin
         advance();
         chk("to_wait_await", awaiting, 1);
         chk("to_wait_lose", lose, 0);
      end
      advance();
      chk("to_lose", lose, 1);
      chk("to_cause", lose_cause, 1);
      chk("to_round", round, 1);

      // Correct press in the expiring cycle wins over the timeout.
      begin_game(16'($urandom));
      advance();
      replay(1, 1'b0);
      press_all(1);
      advance();
      replay(2, 1'b0);
      for (int k = 0; k < TO - 1; k++) advance();
      chk("late_pre_await", awaiting, 1);
      btn_valid = 1'b1;
      btn_color = exp_seq[0];
      advance();
      chk("late_step", step, 1);
      chk("late_await", awaiting, 1);
      chk("late_lose", lose, 0);
      for (int k = 0; k < TO - 1; k++) begin
         advance();
         chk("restart_await", awaiting, 1);
      end
      advance();
      chk("restart_lose", lose, 1);
      chk("restart_cause", lose_cause, 1);
      chk("restart_round", round, 2);

      // Seed 0 behaves as 16'hACE1.
      play_game(16'h0000, 1'b0);
      for (int i = 0; i < MAX_LEN; i++) save_seq[i] = obs_seq[i];
      play_game(16'hACE1, 1'b0);
      for (int i = 0; i < MAX_LEN; i++) chk("seed0_vs_ace1", obs_seq[i], save_seq[i]);

      // Random seed, then a slower timebase: one tick every 3rd cycle.
      play_game(16'($urandom), 1'b0);
      tper = 3;
      play_game(16'hACE1, 1'b0);
      for (int i = 0; i < MAX_LEN; i++) chk("slow_seq", obs_seq[i], save_seq[i]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
